// File: rtl/wb_burst_biu.sv
// rtl/wb_burst_biu.sv - Wishbone pipelined burst bus interface for cacheline fills and writebacks
module wb_burst_biu #(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       i_wb_clk,
    input  logic                       i_wb_rst,
    input  logic                       i_wb_ack,
    input  logic                       i_wb_err,
    input  logic                       i_wb_stall,
    input  logic [WB_DATA_WIDTH-1:0]   i_wb_data,
    output logic                       o_wb_cyc,
    output logic                       o_wb_stb,
    output logic                       o_wb_we,
    output logic [WB_DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [WB_ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [WB_DATA_WIDTH-1:0]   o_wb_data,
    input  logic                       i_biu_en,
    input  logic                       i_biu_we,
    input  logic [WB_ADDR_WIDTH-1:0]   i_biu_addr,
    input  logic [LINE_WIDTH-1:0]      i_biu_data,
    input  logic [LINE_WIDTH/8-1:0]    i_biu_sel,
    output logic [LINE_WIDTH-1:0]      o_biu_data,
    output logic                       o_biu_busy,
    output logic                       o_biu_done,
    output logic                       o_biu_err
);
    localparam int N  = LINE_WIDTH / WB_DATA_WIDTH;
    localparam int B  = WB_DATA_WIDTH / 8;
    localparam int LB = $clog2(B);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] BEATS     = CW'(N);
    localparam logic [CW-1:0] SLOT_MASK = CW'(N - 1);
    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [WB_ADDR_WIDTH-1:0] OFF_MASK = WB_ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [WB_ADDR_WIDTH-1:0] IDX_MASK = WB_ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {IDLE, REQS, ACKS, DONE} state_t;

    state_t                    state, state_n;
    logic                      we_q;
    logic [WB_ADDR_WIDTH-1:0]  base_q;
    logic [CW-1:0]             s_q;
    logic [LINE_WIDTH-1:0]     data_q;
    logic [LINE_WIDTH/8-1:0]   sel_q;
    logic                      err_q;
    logic [CW-1:0]             req_cnt, ack_cnt, outst;
    logic [CW-1:0]             req_cnt_n, ack_cnt_n, req_slot, ack_slot;
    logic                      busy, accept, ack_v, err_v;

    // Handshake qualification and wrap-order slot selection
    always_comb begin
        busy      = (state == REQS) || (state == ACKS);
        o_wb_stb  = (state == REQS) && (req_cnt < BEATS) && (outst < MAX_OUT);
        accept    = o_wb_stb && !i_wb_stall;
        err_v     = busy && i_wb_err;
        ack_v     = busy && (outst != '0) && i_wb_ack && !i_wb_err;
        req_cnt_n = req_cnt + CW'(accept);
        ack_cnt_n = ack_cnt + CW'(ack_v);
        req_slot  = (s_q + req_cnt) & SLOT_MASK;
        ack_slot  = (s_q + ack_cnt) & SLOT_MASK;
    end

    assign o_wb_cyc   = busy;
    assign o_biu_busy = busy;
    assign o_biu_done = (state == DONE);
    assign o_biu_err  = err_q && (state == DONE);
    assign o_wb_we    = we_q;
    assign o_wb_addr  = base_q | (WB_ADDR_WIDTH'(req_slot) << LB);
    assign o_wb_data  = data_q[int'(req_slot)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign o_wb_sel   = !busy ? '0 : (we_q ? sel_q[int'(req_slot)*B +: B] : '1);

    // State register
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state logic; error termination takes priority over acks
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (i_biu_en) state_n = REQS;
            REQS: begin
                if (err_v)                   state_n = DONE;
                else if (ack_cnt_n == BEATS) state_n = DONE;
                else if (req_cnt_n == BEATS) state_n = ACKS;
            end
            ACKS: if (err_v || ack_cnt_n == BEATS) state_n = DONE;
            DONE: if (!i_biu_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture, beat counters and error flag
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            we_q    <= 1'b0;
            base_q  <= '0;
            s_q     <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            req_cnt <= '0;
            ack_cnt <= '0;
            outst   <= '0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
            if (i_biu_en) begin
                we_q    <= i_biu_we;
                base_q  <= i_biu_addr & ~OFF_MASK;
                s_q     <= CW'((i_biu_addr >> LB) & IDX_MASK);
                data_q  <= i_biu_data;
                sel_q   <= i_biu_sel;
                req_cnt <= '0;
                ack_cnt <= '0;
                outst   <= '0;
            end
        end else begin
            req_cnt <= req_cnt_n;
            ack_cnt <= ack_cnt_n;
            outst   <= outst + CW'(accept) - CW'(ack_v);
            if (err_v) err_q <= 1'b1;
        end
    end

    // Read line assembly; the line buffer keeps its contents across reset
    always_ff @(posedge i_wb_clk) begin
        if (ack_v && !we_q)
            o_biu_data[int'(ack_slot)*WB_DATA_WIDTH +: WB_DATA_WIDTH] <= i_wb_data;
    end
endmodule

// File: doc/wb_burst_biu.md
WB_BURST_BIU -- requirements
Module: wb_burst_biu

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  WB_DATA_WIDTH  32   Wishbone data width in bits; a power of 2, at least 8.
  WB_ADDR_WIDTH  32   Wishbone and CCU byte-address width.
  LINE_WIDTH     128  cacheline width in bits; a power-of-2 multiple of WB_DATA_WIDTH.
  MAX_OUTSTANDING 2   maximum accepted-but-unacknowledged requests; 1..N.
  Derived: N = LINE_WIDTH/WB_DATA_WIDTH beats; B = WB_DATA_WIDTH/8 bytes per beat.
REQ-002 Ports (name, direction, width, meaning), one per line:
  i_wb_clk    in   1     single clock.
  i_wb_rst    in   1     reset, asynchronous, active-high.
  i_wb_ack    in   1     beat acknowledge.
  i_wb_err    in   1     beat error termination.
  i_wb_stall  in   1     slave cannot accept a request.
  i_wb_data   in   WB_DATA_WIDTH   read data.
  o_wb_cyc    out  1     bus cycle active.
  o_wb_stb    out  1     request strobe.
  o_wb_we     out  1     write enable.
  o_wb_sel    out  B     byte select.
  o_wb_addr   out  WB_ADDR_WIDTH   beat byte address.
  o_wb_data   out  WB_DATA_WIDTH   write data.
  i_biu_en    in   1     CCU transaction request, level.
  i_biu_we    in   1     1 = line write, 0 = line read.
  i_biu_addr  in   WB_ADDR_WIDTH   byte address; selects the critical beat.
  i_biu_data  in   LINE_WIDTH      write line.
  i_biu_sel   in   LINE_WIDTH/8    write byte mask.
  o_biu_data  out  LINE_WIDTH      read line.
  o_biu_busy  out  1     transaction in progress.
  o_biu_done  out  1     transaction complete.
  o_biu_err   out  1     transaction terminated by error; valid while o_biu_done = 1.

Function
REQ-003 The block uses the states IDLE, REQS, ACKS and DONE.
REQ-004 In IDLE with i_biu_en = 1, the block captures i_biu_we, i_biu_addr, i_biu_data and i_biu_sel, then moves to REQS. Later changes to these inputs have no effect until the block returns to IDLE.
REQ-005 Beats are issued in critical-word-first wrap order.
  - s = captured address bits [log2(LINE_WIDTH/8)-1 : log2(B)].
  - Beat k (k = 0..N-1) targets slot w = (s+k) mod N.
  - o_wb_addr = line base (offset bits cleared) + w*B.
REQ-006 o_wb_stb = 1 in REQS when requests remain and outstanding < MAX_OUTSTANDING; otherwise 0.
  - A request is accepted when o_wb_stb = 1 and i_wb_stall = 0.
  - o_wb_addr, o_wb_data and o_wb_sel hold stable while stalled.
REQ-007 For writes, o_wb_data and o_wb_sel carry slot w of the captured data and mask. For reads, o_wb_sel is all ones.
REQ-008 An ack counts only while o_wb_cyc = 1 and outstanding > 0; any other ack is ignored.
  - On a read, the k-th counted ack writes i_wb_data into o_biu_data slot (s+k) mod N.
REQ-009 If a request is accepted and an ack arrives in the same cycle, outstanding is unchanged.
REQ-010 REQS moves to ACKS in the cycle after all N requests are accepted.
  - ACKS moves to DONE in the cycle after the N-th ack.
  - A single-cycle path REQS -> DONE is allowed when the last request and the last ack coincide.
REQ-011 If i_wb_err = 1 while o_wb_cyc = 1, the block moves to DONE on the next edge with o_biu_err = 1.
  - No further requests are issued and remaining acks are discarded.
  - If ack and err coincide, err wins.
REQ-012 o_wb_cyc = o_biu_busy = 1 exactly in REQS and ACKS. o_biu_done = 1 exactly in DONE.
REQ-013 DONE moves to IDLE when i_biu_en = 0. o_biu_err clears on leaving DONE.
REQ-014 i_biu_en = 0 during REQS or ACKS does not abort the transaction.
REQ-015 Counters are sized log2(N)+1 bits. The beat index wraps modulo N with no carry into the line base.

Reset
REQ-016 i_wb_rst = 1 forces the following asynchronously, including in the middle of a transaction:
  - state = IDLE, with all counters cleared.
  - o_wb_cyc = o_wb_stb = o_biu_busy = o_biu_done = o_biu_err = 0.
  - o_wb_we = 0, o_wb_sel = 0, o_wb_addr = 0, o_wb_data = 0.
  - o_biu_data is not reset.

Verification
REQ-017 The bench covers these scenarios with default parameters:
  - Read, addr 0x1008, no stall, ack 1 cycle after each request -> o_wb_addr sequence 0x1008, 0x100C, 0x1000, 0x1004; o_biu_data slots 2, 3, 0, 1 filled; o_biu_done = 1, o_biu_err = 0.
  - Write, addr 0x2000, mask 0x00F0, i_wb_stall = 1 for 3 cycles on beat 1 -> each beat is accepted exactly once, in order, with addr 0x2004 and data stable during the stall; beat 1 has o_wb_sel = 0xF and the other beats 0x0.
  - Read with acks withheld for 5 cycles -> o_wb_stb drops after 2 accepted requests and resumes on the next ack.
  - Read with i_wb_err on the 2nd ack -> next cycle: o_wb_cyc = 0, o_biu_done = 1, o_biu_err = 1; a stray later ack changes nothing.
  - Reset asserted in ACKS -> all outputs are 0 immediately; a fresh request afterwards completes normally.
  - Spurious ack in IDLE; i_biu_en dropped during REQS -> no state or data change, and the transaction finishes.
